// File: rtl/mul_block_pkg.sv
// rtl/mul_block_pkg.sv - shared types and scaling helper for the block-scaling multiplier
package mul_block_pkg;

  typedef enum logic {IDLE = 1'b0, WORK = 1'b1} state_t;

  localparam int CTX_COEF_W = 32;
  localparam int CTX_EXT_W  = 16;

  typedef struct packed {
    state_t                       state;
    logic signed [CTX_COEF_W-1:0] coeff;
    logic [CTX_EXT_W-1:0]         max;
    logic [CTX_EXT_W-1:0]         h;
    logic [CTX_EXT_W-1:0]         v;
  } ctx_t;

  // Round-half-up arithmetic shift, then clamp into a signed prod_w-bit range.
  function automatic logic signed [63:0] scale_sat(input logic signed [63:0] p,
                                                   input int shift, input int prod_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = p;
    if (shift > 0) r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (prod_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (prod_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/mul_block_n_if.sv
// rtl/mul_block_n_if.sv - first-word fall-through FIFO read/write port bundles
interface read_interface #(parameter int DW = 8, parameter int FLUX = 2);
  logic [DW-1:0]   dout;
  logic [FLUX-1:0] empty;
  logic [FLUX-1:0] read;
  modport actor (input dout, input empty, output read);
  modport fifo  (output dout, output empty, input read);
endinterface

interface write_interface #(parameter int DW = 8, parameter int FLUX = 2);
  logic [DW-1:0]   din;
  logic [FLUX-1:0] full;
  logic [FLUX-1:0] write;
  modport actor (output din, output write, input full);
  modport fifo  (input din, input write, output full);
endinterface

// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - combinational round-robin grant starting after last
module mul_rr_arbiter #(
  parameter int FLUX  = 2,
  parameter int TAG_W = $clog2(FLUX)
) (
  input  logic [FLUX-1:0]  req,
  input  logic [TAG_W-1:0] last,
  output logic [FLUX-1:0]  grant,
  output logic [TAG_W-1:0] idx,
  output logic             valid
);

  logic [TAG_W-1:0] cand;

  // Walk from lowest to highest priority so the nearest requester after last wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = FLUX; k >= 1; k--) begin
      cand = TAG_W'((int'(last) + k) % FLUX);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_block_n.sv
// rtl/mul_block_n.sv - multi-flux block-scaling multiplier actor with round-robin service
module mul_block_n
  import mul_block_pkg::*;
#(
  parameter int FLUX     = 2,
  parameter int A_W      = 8,
  parameter int A_SIGNED = 0,
  parameter int COEF_W   = 9,
  parameter int EXT_W    = 7,
  parameter int SHIFT    = 0,
  parameter int PROD_W   = 18
) (
  input  logic            clk,
  input  logic            rst,
  read_interface.actor    read_port_opA,
  read_interface.actor    read_port_opB,
  read_interface.actor    read_port_ext_size,
  write_interface.actor   write_port_prod,
  output logic [FLUX-1:0] busy
);

  localparam int TAG_W = $clog2(FLUX);

  ctx_t                ctx [FLUX];
  logic [TAG_W-1:0]    last_served;
  logic [TAG_W-1:0]    sel;
  logic [FLUX-1:0]     req;
  logic [FLUX-1:0]     grant;
  logic                valid;
  logic                fire;
  logic                sel_work;
  logic signed [A_W:0] a_ext;
  logic signed [63:0]  p_full;
  logic signed [63:0]  p_scaled;
  logic [EXT_W-1:0]    n_in;

  always_comb begin
    req  = '0;
    busy = '0;
    for (int i = 0; i < FLUX; i++) begin
      busy[i] = (ctx[i].state == WORK);
      req[i]  = (ctx[i].state == IDLE)
              ? (!read_port_opB.empty[i] && !read_port_ext_size.empty[i])
              : (!read_port_opA.empty[i] && !write_port_prod.full[i]);
    end
  end

  mul_rr_arbiter #(.FLUX(FLUX), .TAG_W(TAG_W)) u_arb (
    .req   (req),
    .last  (last_served),
    .grant (grant),
    .idx   (sel),
    .valid (valid)
  );

  // Strobes are held low while reset is asserted even if FIFOs present data.
  always_comb begin
    fire     = valid && rst;
    sel_work = (ctx[sel].state == WORK);
    n_in     = read_port_ext_size.dout[EXT_W-1:0];
    read_port_opB.read      = (fire && !sel_work) ? grant : '0;
    read_port_ext_size.read = (fire && !sel_work) ? grant : '0;
    read_port_opA.read      = (fire && sel_work) ? grant : '0;
    write_port_prod.write   = (fire && sel_work) ? grant : '0;
    a_ext = (A_SIGNED != 0)
          ? signed'({read_port_opA.dout[A_W-1], read_port_opA.dout[A_W-1:0]})
          : signed'({1'b0, read_port_opA.dout[A_W-1:0]});
    p_full   = 64'(a_ext) * 64'(ctx[sel].coeff);
    p_scaled = scale_sat(p_full, SHIFT, PROD_W);
    write_port_prod.din = (fire && sel_work) ? {sel, p_scaled[PROD_W-1:0]} : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) ctx[i] <= '0;
      last_served <= TAG_W'(FLUX - 1);
    end else if (valid) begin
      last_served <= sel;
      if (!sel_work) begin
        ctx[sel].coeff <= CTX_COEF_W'(signed'(read_port_opB.dout[COEF_W-1:0]));
        ctx[sel].max   <= CTX_EXT_W'(n_in);
        ctx[sel].h     <= '0;
        ctx[sel].v     <= '0;
        ctx[sel].state <= (n_in != '0) ? WORK : IDLE;
      end else if (ctx[sel].h < ctx[sel].max - 1'b1) begin
        ctx[sel].h <= ctx[sel].h + 1'b1;
      end else if (ctx[sel].v < ctx[sel].max - 1'b1) begin
        ctx[sel].h <= '0;
        ctx[sel].v <= ctx[sel].v + 1'b1;
      end else begin
        ctx[sel].h     <= '0;
        ctx[sel].v     <= '0;
        ctx[sel].state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mul_block_n.sv
// tb/tb_mul_block_n.sv - directed self-checking bench for mul_block_n
module tb_mul_block_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] busy0;
  logic [3:0] busy1;
  logic [1:0] busy2;
  int checks = 0;
  int errors = 0;
  int g;
  logic [18:0] exp_t1 [4];

  always #5 clk = ~clk;

  read_interface  #(.DW(9),  .FLUX(2)) a0 ();
  read_interface  #(.DW(10), .FLUX(2)) b0 ();
  read_interface  #(.DW(8),  .FLUX(2)) e0 ();
  write_interface #(.DW(19), .FLUX(2)) p0 ();

  read_interface  #(.DW(10), .FLUX(4)) a1 ();
  read_interface  #(.DW(11), .FLUX(4)) b1 ();
  read_interface  #(.DW(9),  .FLUX(4)) e1 ();
  write_interface #(.DW(20), .FLUX(4)) p1 ();

  read_interface  #(.DW(9),  .FLUX(2)) a2 ();
  read_interface  #(.DW(10), .FLUX(2)) b2 ();
  read_interface  #(.DW(8),  .FLUX(2)) e2 ();
  write_interface #(.DW(9),  .FLUX(2)) p2 ();

  mul_block_n dut0 (
    .clk(clk), .rst(rst), .read_port_opA(a0), .read_port_opB(b0),
    .read_port_ext_size(e0), .write_port_prod(p0), .busy(busy0)
  );

  mul_block_n #(.FLUX(4)) dut1 (
    .clk(clk), .rst(rst), .read_port_opA(a1), .read_port_opB(b1),
    .read_port_ext_size(e1), .write_port_prod(p1), .busy(busy1)
  );

  mul_block_n #(.A_SIGNED(1), .SHIFT(2), .PROD_W(8)) dut2 (
    .clk(clk), .rst(rst), .read_port_opA(a2), .read_port_opB(b2),
    .read_port_ext_size(e2), .write_port_prod(p2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t1 = '{19'h3FFFD, 19'h3FFFA, 19'h3FFF7, 19'h3FFF4};
    a0.dout = '0; b0.dout = '0; e0.dout = '0; p0.full = '0;
    a1.dout = '0; b1.dout = '0; e1.dout = '0; p1.full = '0;
    a2.dout = '0; b2.dout = '0; e2.dout = '0; p2.full = '0;
    a1.empty = 4'hF; b1.empty = 4'hF; e1.empty = 4'hF;
    a2.empty = 2'b11; b2.empty = 2'b11; e2.empty = 2'b11;
    // reset with every dut0 FIFO offering data
    a0.empty = 2'b00; b0.empty = 2'b00; e0.empty = 2'b00;
    repeat (2) tick();
    chk("rst_opB_read", 32'(b0.read), 0);
    chk("rst_opA_read", 32'(a0.read), 0);
    chk("rst_write", 32'(p0.write), 0);
    chk("rst_din", 32'(p0.din), 0);
    chk("rst_busy", 32'(busy0), 0);
    a0.empty = 2'b11; b0.empty = 2'b11; e0.empty = 2'b11;
    tick();
    rst = 1'b1;

    // single block, flux 0, N=2, coeff -3
    tick();
    b0.empty = 2'b10; e0.empty = 2'b10;
    b0.dout = {1'b0, 9'h1FD}; e0.dout = {1'b0, 7'd2};
    #1;
    chk("t1_load_opB", 32'(b0.read), 32'b01);
    chk("t1_load_ext", 32'(e0.read), 32'b01);
    chk("t1_load_nowrite", 32'(p0.write), 0);
    tick();
    b0.empty = 2'b11; e0.empty = 2'b11; a0.empty = 2'b10;
    for (int k = 0; k < 4; k++) begin
      a0.dout = {1'b0, 8'(k + 1)};
      #1;
      chk("t1_busy", 32'(busy0), 32'b01);
      chk("t1_write", 32'(p0.write), 32'b01);
      chk("t1_din", 32'(p0.din), 32'(exp_t1[k]));
      tick();
    end
    a0.dout = {1'b0, 8'd9};
    #1;
    chk("t1_busy_fall", 32'(busy0), 0);
    chk("t1_idle_opA_kept", 32'(a0.read), 0);
    chk("t1_idle_nowrite", 32'(p0.write), 0);
    a0.empty = 2'b11;

    // zero-size block then N=1 on flux 1
    b0.empty = 2'b01; e0.empty = 2'b01;
    b0.dout = {1'b1, 9'd5}; e0.dout = {1'b1, 7'd0};
    #1;
    chk("t2_zero_opB", 32'(b0.read), 32'b10);
    chk("t2_zero_ext", 32'(e0.read), 32'b10);
    tick();
    b0.dout = {1'b1, 9'd2}; e0.dout = {1'b1, 7'd1};
    #1;
    chk("t2_zero_busy", 32'(busy0), 0);
    chk("t2_zero_nowrite", 32'(p0.write), 0);
    chk("t2_second_opB", 32'(b0.read), 32'b10);
    tick();
    b0.empty = 2'b11; e0.empty = 2'b11;
    a0.empty = 2'b01; a0.dout = {1'b1, 8'd7};
    #1;
    chk("t2_busy", 32'(busy0), 32'b10);
    chk("t2_write", 32'(p0.write), 32'b10);
    chk("t2_din", 32'(p0.din), 32'h4000E);
    tick();
    a0.empty = 2'b11;
    #1;
    chk("t2_done", 32'(busy0), 0);

    // backpressure: both fluxes N=3, prod[0] full for 5 cycles
    b0.empty = 2'b00; e0.empty = 2'b00;
    b0.dout = {1'b0, 9'd1}; e0.dout = {1'b0, 7'd3};
    #1;
    chk("t4_load0", 32'(b0.read), 32'b01);
    tick();
    b0.dout = {1'b1, 9'd1}; e0.dout = {1'b1, 7'd3};
    #1;
    chk("t4_load1", 32'(b0.read), 32'b10);
    tick();
    b0.empty = 2'b11; e0.empty = 2'b11;
    a0.empty = 2'b00; p0.full = 2'b01; a0.dout = {1'b1, 8'd10};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_bp_write", 32'(p0.write), 32'b10);
      chk("t4_bp_din", 32'(p0.din), 32'h4000A);
      chk("t4_bp_busy", 32'(busy0), 32'b11);
      tick();
    end
    p0.full = 2'b00;
    for (int k = 0; k < 13; k++) begin
      g = (k < 8) ? (k % 2) : 0;
      a0.dout = {g[0], 8'(k + 20)};
      #1;
      chk("t4_rr_write", 32'(p0.write), 32'(1) << g);
      chk("t4_rr_din", 32'(p0.din), 32'({g[0], 18'(k + 20)}));
      if (k == 12) chk("t4_last_busy", 32'(busy0), 32'b01);
      tick();
    end
    #1;
    chk("t4_done", 32'(busy0), 0);
    a0.empty = 2'b11;

    // four-flux round robin
    b1.empty = 4'h0; e1.empty = 4'h0;
    for (int k = 0; k < 4; k++) begin
      b1.dout = {2'(k), 9'd1}; e1.dout = {2'(k), 7'd4};
      #1;
      chk("t5_load", 32'(b1.read), 32'(1) << k);
      tick();
    end
    b1.empty = 4'hF; e1.empty = 4'hF; a1.empty = 4'h0;
    for (int k = 0; k < 8; k++) begin
      a1.dout = {2'(k % 4), 8'(k)};
      #1;
      chk("t5_busy", 32'(busy1), 32'hF);
      chk("t5_grant", 32'(p1.write), 32'(1) << (k % 4));
      chk("t5_din", 32'(p1.din), 32'({2'(k % 4), 18'(k)}));
      tick();
    end
    a1.empty = 4'hF;

    // scaling and saturation, plus legacy unsigned extreme
    b2.empty = 2'b10; e2.empty = 2'b10;
    b2.dout = {1'b0, 9'h0FF}; e2.dout = {1'b0, 7'd1};
    #1;
    chk("t6_load_a", 32'(b2.read), 32'b01);
    tick();
    b2.empty = 2'b11; e2.empty = 2'b11;
    a2.empty = 2'b10; a2.dout = {1'b0, 8'h80};
    #1;
    chk("t6_neg_sat", 32'(p2.din), 32'h080);
    tick();
    a2.empty = 2'b11;
    b2.empty = 2'b10; e2.empty = 2'b10; b2.dout = {1'b0, 9'd2};
    tick();
    b2.empty = 2'b11; e2.empty = 2'b11;
    a2.empty = 2'b10; a2.dout = {1'b0, 8'd3};
    #1;
    chk("t6_round", 32'(p2.din), 32'h002);
    tick();
    a2.empty = 2'b11;
    b2.empty = 2'b10; e2.empty = 2'b10; b2.dout = {1'b0, 9'h0FF};
    tick();
    b2.empty = 2'b11; e2.empty = 2'b11;
    a2.empty = 2'b10; a2.dout = {1'b0, 8'd127};
    #1;
    chk("t6_pos_sat", 32'(p2.din), 32'h07F);
    tick();
    a2.empty = 2'b11;
    b0.empty = 2'b10; e0.empty = 2'b10;
    b0.dout = {1'b0, 9'h100}; e0.dout = {1'b0, 7'd1};
    tick();
    b0.empty = 2'b11; e0.empty = 2'b11;
    a0.empty = 2'b10; a0.dout = {1'b0, 8'hFF};
    #1;
    chk("t6_legacy", 32'(p0.din), 32'h30100);
    tick();
    a0.empty = 2'b11;

    // asynchronous reset during the third sample of an N=3 block
    b0.empty = 2'b10; e0.empty = 2'b10;
    b0.dout = {1'b0, 9'd1}; e0.dout = {1'b0, 7'd3};
    tick();
    b0.empty = 2'b11; e0.empty = 2'b11; a0.empty = 2'b10;
    for (int k = 0; k < 2; k++) begin
      a0.dout = {1'b0, 8'(k + 1)};
      tick();
    end
    a0.dout = {1'b0, 8'd3};
    #1;
    chk("t7_pre_write", 32'(p0.write), 32'b01);
    rst = 1'b0;
    #1;
    chk("t7_rst_write", 32'(p0.write), 0);
    chk("t7_rst_opA", 32'(a0.read), 0);
    chk("t7_rst_din", 32'(p0.din), 0);
    chk("t7_rst_busy", 32'(busy0), 0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t7_opA_held", 32'(a0.read), 0);
      chk("t7_idle", 32'(busy0), 0);
      tick();
    end
    b0.empty = 2'b10; e0.empty = 2'b10;
    #1;
    chk("t7_new_pair", 32'(b0.read), 32'b01);
    tick();
    b0.empty = 2'b11; e0.empty = 2'b11;
    #1;
    chk("t7_opA_consumed", 32'(a0.read), 32'b01);
    chk("t7_din", 32'(p0.din), 32'd3);
    tick();
    a0.empty = 2'b11;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_block_n.md
# mul_block_n

Parametrised multi-flux block-scaling multiplier actor for the HEVC dataflow datapath. For each flux it takes one coefficient and one block size N from the opB and ext_size FIFOs. It then multiplies the next N×N opA samples by that coefficient, applies optional rounding right-shift and saturation, and writes tagged products to the prod FIFO. It replaces the fixed-width, fixed-priority 9-bit multiplier. The generalisations are configurable widths, signed or unsigned opA, post-scaling, round-robin arbitration across fluxes, zero-size blocks, and a per-flux busy status.

## Interface
- FLUX, 2: number of interleaved data fluxes (≥2); TAG_W = $clog2(FLUX)
- A_W, 8: opA data width
- A_SIGNED, 0: 0 = opA zero-extended by 1 bit; 1 = opA sign-extended by 1 bit
- COEF_W, 9: signed coefficient width
- EXT_W, 7: block-size field width
- SHIFT, 0: arithmetic right shift applied to the full product
- PROD_W, 18: signed output data width
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous assert, active-low, released synchronously to clk
- read_port_opA  read_interface.actor  dout TAG_W+A_W; empty/read FLUX  sample stream
- read_port_opB  read_interface.actor  dout TAG_W+COEF_W; empty/read FLUX  coefficient stream
- read_port_ext_size  read_interface.actor  dout TAG_W+EXT_W; empty/read FLUX  block size N
- write_port_prod  write_interface.actor  din TAG_W+PROD_W; full/write FLUX  tagged products {tag, data}
- busy  output  FLUX  bit i = flux i in WORK

## Operation
- Per-flux context, held in registers: state (IDLE/WORK), coeff, max N, horizontal counter h, vertical counter v.
- Flux i is eligible when either holds:
  - IDLE, opB not empty and ext_size not empty;
  - WORK, opA not empty and prod not full.
- Arbitration:
  - At most one flux is served per cycle.
  - Selection is round-robin, starting at (last_served+1) mod FLUX.
  - last_served updates only on a served cycle.
- Served flux in IDLE:
  - Pulse read on opB[i] and ext_size[i].
  - Load coeff and N.
  - Clear h and v.
  - If N≠0, go to WORK. If N=0, stay IDLE and produce no output.
- Served flux in WORK:
  - Pulse read on opA[i] and write on prod[i]; din = {i, result}.
  - If h<N−1: h++.
  - Else if v<N−1: h=0, v++.
  - Else: h=v=0, go to IDLE.
  - Exactly N·N products are emitted per block.
- Arithmetic:
  - Extend opA to A_W+1 bits signed, per A_SIGNED.
  - P = ext(opA) × coeff, full width A_W+1+COEF_W.
  - If SHIFT>0: P = (P + 2^(SHIFT−1)) >>> SHIFT (round half up).
  - Saturate P to signed PROD_W.
  - Defaults reproduce the legacy bit-exact unsigned×signed 18-bit product.
- Only the strobe for the selected flux is asserted; every other read/write bit is 0.
- Strobes and din are don't-care-free: din = 0 when no write is pulsed.

## Timing
- FIFOs are first-word fall-through. Eligibility, strobes and din are combinational in the same cycle. Context updates on the following rising clk.
- Throughput is one transaction per cycle across all fluxes. Latency is 0 cycles from opA valid to prod write.
- A saturated prod[i] stalls only flux i. Other fluxes continue to be served.
- opA arriving for an IDLE flux is never consumed.
- Reset values, while rst=0:
  - all read/write strobes = 0, din = 0, busy = 0;
  - all states IDLE, h = v = 0, last_served = FLUX−1.
- Reset asserted mid-block discards the block. After release each flux waits for a new opB/ext_size pair.
- An N=FLUX-wide tie, with every flux eligible, serves each flux once per FLUX cycles.
- N = 2^EXT_W−1 is legal; the counters never wrap.

## Structure
- Package mul_block_pkg holds:
  - state_t enum {IDLE, WORK};
  - the ctx_t struct {state, coeff, max, h, v};
  - the function scale_sat(P), which does the rounding shift and saturation.
- Sub-module mul_rr_arbiter: FLUX request bits plus last_served in, one-hot grant plus index out. It is purely combinational; the pointer register stays in the top level.

## Test plan
- Single block, flux 0, N=2, coeff=−3, opA = 1,2,3,4:
  - prod[0] = {0,−3}, {0,−6}, {0,−9}, {0,−12};
  - busy[0] falls after the 4th write.
- Zero size, flux 1, N=0, coeff=5, then N=1, coeff=2, opA=7:
  - the first pair is consumed with no output;
  - the single product is {1,14}.
- Round-robin, FLUX=4, all fluxes WORK with opA always available:
  - grants run 0,1,2,3,0… with no flux served twice in 4 cycles.
- Backpressure: prod[0] full for 5 cycles while flux 1 is active.
  - Flux 1 emits 5 products.
  - Flux 0 counters are unchanged, then resume exactly.
- Scaling, SHIFT=2, PROD_W=8, A_SIGNED=1:
  - opA=−128, coeff=255 → −128 (saturated);
  - opA=3, coeff=2 → 2 (rounded 6/4).
- Reset pulse (rst low, asynchronous) during the 3rd sample of an N=3 block:
  - strobes go to 0 immediately and busy=0;
  - the leftover opA is not consumed until a new coeff/size pair arrives.
